// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// slave = window generator side, master = pixel source plus window consumer side.
interface conv_window_gen_if #(
   parameter int DATA_BITS   = 8,
   parameter int FILTER_SIZE = 5,
   parameter int CHANNELS    = 1
);
   localparam int PIX_W = CHANNELS * DATA_BITS;
   localparam int WIN_W = FILTER_SIZE * FILTER_SIZE * PIX_W;

   logic             in_val;
   logic             in_rdy;
   logic             in_sof;
   logic [PIX_W-1:0] data_in;
   logic             out_val;
   logic             out_rdy;
   logic [WIN_W-1:0] data_out;
   logic             frame_done;

   modport master (
      output in_val, in_sof, data_in, out_rdy,
      input  in_rdy, out_val, data_out, frame_done
   );

   modport slave (
      input  in_val, in_sof, data_in, out_rdy,
      output in_rdy, out_val, data_out, frame_done
   );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding F x F x CHANNELS window generator with stride and SOF resync; window valid 1 cycle after its last pixel.
// Single output register: in_rdy = !out_val | out_rdy, so a held window stalls the pixel stream.
module conv_window_gen #(
   parameter int WIDTH       = 28,
   parameter int HEIGHT      = 28,
   parameter int DATA_BITS   = 8,
   parameter int FILTER_SIZE = 5,
   parameter int CHANNELS    = 1,
   parameter int STRIDE      = 1
) (
   input  logic               clk,
   input  logic               rst,
   conv_window_gen_if.slave   io
);
   localparam int F     = FILTER_SIZE;
   localparam int PIX_W = CHANNELS * DATA_BITS;
   localparam int WIN_W = F * F * PIX_W;
   localparam int CW    = $clog2(WIDTH);
   localparam int RW    = $clog2(HEIGHT);
   localparam int PW    = $clog2(STRIDE + 1);

   typedef logic [PIX_W-1:0] pix_t;

   logic [CW-1:0]    col_q, col_d, ec;
   logic [RW-1:0]    row_q, row_d, er;
   logic [PW-1:0]    cph_q, cph_d, ecph;
   logic [PW-1:0]    rph_q, rph_d, erph;
   logic             out_val_q, out_val_d;
   logic             fd_q, fd_d;
   logic [WIN_W-1:0] dout_q, dout_d, win_flat;
   logic             acc, emit, last_col, last_row;

   pix_t lb_q    [F-1][WIDTH];
   pix_t win_q   [F][F];
   pix_t win_d   [F][F];
   pix_t col_vec [F];

   assign acc           = io.in_val & io.in_rdy;
   assign io.in_rdy     = ~out_val_q | io.out_rdy;
   assign io.out_val    = out_val_q;
   assign io.data_out   = dout_q;
   assign io.frame_done = fd_q;

   // An SOF beat is treated as (0,0) with zero phases, whatever the counters say.
   always_comb begin
      ec   = io.in_sof ? '0 : col_q;
      er   = io.in_sof ? '0 : row_q;
      ecph = io.in_sof ? '0 : cph_q;
      erph = io.in_sof ? '0 : rph_q;
   end

   always_comb begin
      for (int k = 0; k < F - 1; k++) col_vec[k] = lb_q[k][ec];
      col_vec[F-1] = io.data_in;
      for (int r = 0; r < F; r++) begin
         for (int c = 0; c < F - 1; c++) win_d[r][c] = win_q[r][c+1];
         win_d[r][F-1] = col_vec[r];
      end
      win_flat = '0;
      for (int r = 0; r < F; r++)
         for (int c = 0; c < F; c++)
            win_flat[(r*F+c)*PIX_W +: PIX_W] = win_d[r][c];
   end

   // Phases stay 0 until the first full window column/row, then count modulo STRIDE.
   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      cph_d     = cph_q;
      rph_d     = rph_q;
      out_val_d = out_val_q;
      dout_d    = dout_q;
      last_col  = (ec == CW'(WIDTH - 1));
      last_row  = (er == RW'(HEIGHT - 1));
      emit      = acc && (ec >= CW'(F - 1)) && (er >= RW'(F - 1)) && (ecph == '0) && (erph == '0);
      fd_d      = acc & last_col & last_row;
      if (acc) begin
         if (last_col) begin
            col_d = '0;
            cph_d = '0;
            if (last_row) begin
               row_d = '0;
               rph_d = '0;
            end else begin
               row_d = er + 1'b1;
               rph_d = (er < RW'(F - 1) || erph == PW'(STRIDE - 1)) ? '0 : erph + 1'b1;
            end
         end else begin
            col_d = ec + 1'b1;
            cph_d = (ec < CW'(F - 1) || ecph == PW'(STRIDE - 1)) ? '0 : ecph + 1'b1;
            row_d = er;
            rph_d = erph;
         end
      end
      if (emit) begin
         out_val_d = 1'b1;
         dout_d    = win_flat;
      end else if (io.out_rdy) begin
         out_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q     <= '0;
         row_q     <= '0;
         cph_q     <= '0;
         rph_q     <= '0;
         out_val_q <= 1'b0;
         fd_q      <= 1'b0;
         dout_q    <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         cph_q     <= cph_d;
         rph_q     <= rph_d;
         out_val_q <= out_val_d;
         fd_q      <= fd_d;
         dout_q    <= dout_d;
      end
   end

   // Line buffers shift up one row at the accepted column; lb_q[0] holds the oldest row.
   always_ff @(posedge clk) begin
      if (acc && !rst) begin
         for (int k = 0; k < F - 2; k++) lb_q[k][ec] <= lb_q[k+1][ec];
         lb_q[F-2][ec] <= io.data_in;
         win_q <= win_d;
      end
   end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench: default 28x28/5x5, stride-2, and 8x6/3x3x3-channel instances sharing clk/rst.
module tb_conv_window_gen;
   typedef logic [199:0] wa_t;
   typedef logic [215:0] wc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   conv_window_gen_if #(.DATA_BITS(8), .FILTER_SIZE(5), .CHANNELS(1)) ia ();
   conv_window_gen_if #(.DATA_BITS(8), .FILTER_SIZE(5), .CHANNELS(1)) ib ();
   conv_window_gen_if #(.DATA_BITS(8), .FILTER_SIZE(3), .CHANNELS(3)) ic ();

   conv_window_gen #(.WIDTH(28), .HEIGHT(28), .DATA_BITS(8), .FILTER_SIZE(5), .CHANNELS(1), .STRIDE(1))
      dut_a (.clk(clk), .rst(rst), .io(ia));
   conv_window_gen #(.WIDTH(28), .HEIGHT(28), .DATA_BITS(8), .FILTER_SIZE(5), .CHANNELS(1), .STRIDE(2))
      dut_b (.clk(clk), .rst(rst), .io(ib));
   conv_window_gen #(.WIDTH(8), .HEIGHT(6), .DATA_BITS(8), .FILTER_SIZE(3), .CHANNELS(3), .STRIDE(1))
      dut_c (.clk(clk), .rst(rst), .io(ic));

   // Captured windows with the number of beats accepted before the capture cycle.
   wa_t qa[$]; int qa_acc[$]; int fda[$]; int acc_a = 0;
   wa_t qb[$]; int fdb[$];
   wc_t qc[$]; int fdc[$]; int acc_c = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (ia.frame_done) fda.push_back(acc_a);
         if (ia.out_val && ia.out_rdy) begin qa.push_back(ia.data_out); qa_acc.push_back(acc_a); end
         if (ia.in_val && ia.in_rdy) acc_a++;
         if (ib.frame_done) fdb.push_back(0);
         if (ib.out_val && ib.out_rdy) qb.push_back(ib.data_out);
         if (ic.frame_done) fdc.push_back(acc_c);
         if (ic.out_val && ic.out_rdy) qc.push_back(ic.data_out);
         if (ic.in_val && ic.in_rdy) acc_c++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic wa_t exp_a(input int br_row, input int br_col, input int off);
      wa_t v = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            v[(r*5+c)*8 +: 8] = 8'((br_row - 4 + r) * 28 + br_col - 4 + c + off);
      return v;
   endfunction

   function automatic int bad_wins_a(input wa_t q[$], input int first, input int nwin,
                                     input int stride, input int off);
      int nx = 23 / stride + 1;
      int n  = 0;
      for (int k = 0; k < nwin; k++) begin
         if (first + k >= q.size()) n++;
         else if (q[first+k] !== exp_a(4 + (k / nx) * stride, 4 + (k % nx) * stride, off)) n++;
      end
      return n;
   endfunction

   function automatic wc_t exp_c(input int br_row, input int br_col, input int off);
      wc_t v = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            for (int ch = 0; ch < 3; ch++)
               v[((r*3+c)*3+ch)*8 +: 8] = 8'(((br_row - 2 + r) * 8 + br_col - 2 + c) * 3 + ch + off);
      return v;
   endfunction

   // Sends n beats to instance sel; pixel i carries (i+off) per channel formula; in_sof on beat sof_idx.
   task automatic drive(input int sel, input int n, input int off, input int sof_idx);
      for (int i = 0; i < n; i++) begin
         int  w   = 0;
         logic rdy;
         case (sel)
            0: begin ia.in_val = 1'b1; ia.in_sof = (i == sof_idx); ia.data_in = 8'(i + off); end
            1: begin ib.in_val = 1'b1; ib.in_sof = (i == sof_idx); ib.data_in = 8'(i + off); end
            default: begin
               ic.in_val = 1'b1; ic.in_sof = (i == sof_idx);
               for (int ch = 0; ch < 3; ch++) ic.data_in[ch*8 +: 8] = 8'(i * 3 + ch + off);
            end
         endcase
         @(negedge clk);
         rdy = (sel == 0) ? ia.in_rdy : (sel == 1) ? ib.in_rdy : ic.in_rdy;
         while (!rdy && w < 200) begin
            @(negedge clk);
            w++;
            rdy = (sel == 0) ? ia.in_rdy : (sel == 1) ? ib.in_rdy : ic.in_rdy;
         end
         if (!rdy) begin
            total++; bad++;
            $display("FAIL drive_timeout: dut=%0d beat=%0d in_rdy=%0b required 1", sel, i, rdy);
            break;
         end
         @(posedge clk); #1;
      end
      ia.in_val = 1'b0; ia.in_sof = 1'b0;
      ib.in_val = 1'b0; ib.in_sof = 1'b0;
      ic.in_val = 1'b0; ic.in_sof = 1'b0;
   endtask

   task automatic clear_a();
      qa.delete(); qa_acc.delete(); fda.delete(); acc_a = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (ia.out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val: got %0b want 0", ia.out_val); end
      total++; if (ia.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %0b want 0", ia.frame_done); end
      total++; if (ia.data_out !== '0) begin bad++; $display("FAIL reset_data_out: got %h want 0", ia.data_out); end
      total++; if (ia.in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy: got %0b want 1", ia.in_rdy); end
      total++; if (ic.out_val !== 1'b0) begin bad++; $display("FAIL reset_c_out_val: got %0b want 0", ic.out_val); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_frame();
      wa_t w;
      int  n;
      clear_a();
      drive(0, 784, 0, -1);
      @(negedge clk);
      total++; if (ia.frame_done !== 1'b1) begin bad++; $display("FAIL frame_done_latency: got %0b want 1", ia.frame_done); end
      @(negedge clk);
      total++; if (ia.frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_pulse: got %0b want 0", ia.frame_done); end
      repeat (3) @(posedge clk); #1;
      w = (qa.size() > 0) ? qa[0] : '1;
      total++; if (qa.size() !== 576) begin bad++; $display("FAIL single_count: got %0d want 576", qa.size()); end
      total++; if (qa_acc.size() == 0 || qa_acc[0] !== 117) begin
         bad++; $display("FAIL first_window_latency: got %0d beats before want 117", (qa_acc.size() > 0) ? qa_acc[0] : -1);
      end
      total++; if (w[7:0] !== 8'd0) begin bad++; $display("FAIL first_elem00: got %0d want 0", w[7:0]); end
      total++; if (w[199:192] !== 8'd116) begin bad++; $display("FAIL first_elem44: got %0d want 116", w[199:192]); end
      n = bad_wins_a(qa, 0, 576, 1, 0);
      total++; if (n !== 0) begin bad++; $display("FAIL single_windows: %0d wrong want 0", n); end
      total++; if (fda.size() !== 1) begin bad++; $display("FAIL single_fd_count: got %0d want 1", fda.size()); end
   endtask

   task automatic test_stride();
      wa_t w;
      int  n;
      qb.delete(); fdb.delete();
      drive(1, 784, 0, -1);
      repeat (4) @(posedge clk); #1;
      w = (qb.size() > 1) ? qb[1] : '1;
      total++; if (qb.size() !== 144) begin bad++; $display("FAIL stride_count: got %0d want 144", qb.size()); end
      total++; if (w[7:0] !== 8'd2) begin bad++; $display("FAIL stride_win1_elem00: got %0d want 2", w[7:0]); end
      total++; if (w[199:192] !== 8'd118) begin bad++; $display("FAIL stride_win1_elem44: got %0d want 118", w[199:192]); end
      n = bad_wins_a(qb, 0, 144, 2, 0);
      total++; if (n !== 0) begin bad++; $display("FAIL stride_windows: %0d wrong want 0", n); end
      total++; if (fdb.size() !== 1) begin bad++; $display("FAIL stride_fd_count: got %0d want 1", fdb.size()); end
   endtask

   task automatic test_backpressure();
      int n;
      clear_a();
      fork
         drive(0, 784, 0, -1);
         begin
            int  w = 0;
            wa_t snap;
            @(negedge clk);
            while (!ia.out_val && w < 2000) begin @(negedge clk); w++; end
            total++; if (ia.out_val !== 1'b1) begin bad++; $display("FAIL bp_wait_window: out_val=%0b want 1", ia.out_val); end
            @(posedge clk); #1;
            ia.out_rdy = 1'b0;
            @(negedge clk);
            snap = ia.data_out;
            total++; if (ia.in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy: got %0b want 0", ia.in_rdy); end
            for (int k = 0; k < 9; k++) begin
               @(negedge clk);
               total++; if (ia.in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy: cyc %0d got %0b want 0", k, ia.in_rdy); end
               total++; if (ia.out_val !== 1'b1 || ia.data_out !== snap) begin
                  bad++; $display("FAIL bp_frozen: cyc %0d got %h want %h", k, ia.data_out, snap);
               end
            end
            @(posedge clk); #1;
            ia.out_rdy = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      total++; if (qa.size() !== 576) begin bad++; $display("FAIL bp_count: got %0d want 576", qa.size()); end
      n = bad_wins_a(qa, 0, 576, 1, 0);
      total++; if (n !== 0) begin bad++; $display("FAIL bp_windows: %0d wrong want 0", n); end
      total++; if (acc_a !== 784) begin bad++; $display("FAIL bp_beats: got %0d want 784", acc_a); end
   endtask

   task automatic test_back_to_back();
      int n0, n1;
      clear_a();
      drive(0, 784, 0, -1);
      drive(0, 784, 37, -1);
      repeat (4) @(posedge clk); #1;
      total++; if (qa.size() !== 1152) begin bad++; $display("FAIL b2b_count: got %0d want 1152", qa.size()); end
      n0 = bad_wins_a(qa, 0, 576, 1, 0);
      n1 = bad_wins_a(qa, 576, 576, 1, 37);
      total++; if (n0 + n1 !== 0) begin bad++; $display("FAIL b2b_windows: %0d wrong want 0", n0 + n1); end
      total++; if (fda.size() !== 2) begin bad++; $display("FAIL b2b_fd_count: got %0d want 2", fda.size()); end
      else begin
         total++; if (fda[0] !== 784 || fda[1] - fda[0] !== 784) begin
            bad++; $display("FAIL b2b_fd_spacing: got %0d,%0d want 784,1568", fda[0], fda[1]);
         end
      end
   endtask

   task automatic test_sof();
      int idx, n;
      clear_a();
      drive(0, 300, 0, -1);
      drive(0, 784, 50, 0);
      repeat (4) @(posedge clk); #1;
      idx = 0;
      while (idx < qa_acc.size() && qa_acc[idx] <= 300) idx++;
      total++; if (qa.size() - idx !== 576) begin bad++; $display("FAIL sof_count: got %0d want 576", qa.size() - idx); end
      n = bad_wins_a(qa, idx, 576, 1, 50);
      total++; if (n !== 0) begin bad++; $display("FAIL sof_windows: %0d wrong want 0", n); end
      total++; if (fda.size() !== 1 || fda[0] !== 1084) begin
         bad++; $display("FAIL sof_fd: got %0d pulses first at %0d want 1 at 1084", fda.size(), (fda.size() > 0) ? fda[0] : -1);
      end
   endtask

   task automatic test_reset_midframe();
      wc_t w;
      int  n;
      qc.delete(); fdc.delete(); acc_c = 0;
      drive(2, 20, 0, -1);
      ic.in_val = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      total++; if (ic.out_val !== 1'b1) begin bad++; $display("FAIL mid_pre_rst_val: got %0b want 1", ic.out_val); end
      @(posedge clk); #1;
      rst = 1'b0; ic.in_val = 1'b0;
      @(negedge clk);
      total++; if (ic.out_val !== 1'b0) begin bad++; $display("FAIL mid_rst_out_val: got %0b want 0", ic.out_val); end
      total++; if (ic.data_out !== '0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", ic.data_out); end
      @(posedge clk); #1;
      qc.delete(); fdc.delete(); acc_c = 0;
      drive(2, 48, 1, -1);
      repeat (4) @(posedge clk); #1;
      w = (qc.size() > 0) ? qc[0] : '1;
      total++; if (qc.size() !== 24) begin bad++; $display("FAIL c_count: got %0d want 24", qc.size()); end
      total++; if (w[7:0] !== 8'd1) begin bad++; $display("FAIL c_elem00ch0: got %0d want 1", w[7:0]); end
      total++; if (w[135:128] !== 8'd32) begin bad++; $display("FAIL c_elem12ch1: got %0d want 32", w[135:128]); end
      total++; if (w[215:208] !== 8'd57) begin bad++; $display("FAIL c_elem22ch2: got %0d want 57", w[215:208]); end
      n = 0;
      for (int k = 0; k < 24; k++)
         if (k >= qc.size() || qc[k] !== exp_c(2 + k / 6, 2 + k % 6, 1)) n++;
      total++; if (n !== 0) begin bad++; $display("FAIL c_windows: %0d wrong want 0", n); end
      total++; if (fdc.size() !== 1 || fdc[0] !== 48) begin
         bad++; $display("FAIL c_fd: got %0d pulses first at %0d want 1 at 48", fdc.size(), (fdc.size() > 0) ? fdc[0] : -1);
      end
   endtask

   initial begin
      ia.in_val = 1'b0; ia.in_sof = 1'b0; ia.data_in = '0; ia.out_rdy = 1'b1;
      ib.in_val = 1'b0; ib.in_sof = 1'b0; ib.data_in = '0; ib.out_rdy = 1'b1;
      ic.in_val = 1'b0; ic.in_sof = 1'b0; ic.data_in = '0; ic.out_rdy = 1'b1;
      test_reset();
      test_single_frame();
      test_stride();
      test_backpressure();
      test_back_to_back();
      test_sof();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
